// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard controller: stalls ID for LOAD_LAT cycles behind a load in EX,
// arbitrated against taken-branch flushes and memory freezes; counts stall cycles.
module hazard_ctrl_unit #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              MemRead_EX,
   input  logic [REG_AW-1:0] Rt_EX,
   input  logic [REG_AW-1:0] Rs_ID,
   input  logic [REG_AW-1:0] Rt_ID,
   input  logic              UsesRt_ID,
   input  logic              Branch_Taken_EX,
   input  logic              Mem_Busy,
   input  logic              Stall_Clr,
   output logic              PC_Write,
   output logic              IFID_Write,
   output logic              IDEX_Bubble,
   output logic              IFID_Flush,
   output logic              Freeze,
   output logic              Stall,
   output logic [CNT_W-1:0]  Stall_Cnt
);

   localparam int DW = $clog2(LOAD_LAT) + 1;
   localparam logic [DW-1:0] LAT_M1 = DW'(LOAD_LAT - 1);

   typedef enum logic {IDLE, LSTALL} state_t;

   state_t           state_reg, state_next;
   logic [DW-1:0]    cnt_reg, cnt_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic             hz;
   logic             stall;

   // Register 0 is hardwired, so a load into it can never create a dependency.
   always_comb begin
      hz = MemRead_EX && (Rt_EX != '0) &&
           ((Rs_ID == Rt_EX) || (UsesRt_ID && (Rt_ID == Rt_EX)));
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      stall       = 1'b0;
      PC_Write    = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Bubble = 1'b0;
      IFID_Flush  = 1'b0;
      Freeze      = 1'b0;

      if (!Rst_n) begin
         // outputs held at idle values; state is cleared by the register
      end else if (Mem_Busy) begin
         // whole pipeline frozen; a stall in progress resumes afterwards
         Freeze     = 1'b1;
         PC_Write   = 1'b0;
         IFID_Write = 1'b0;
      end else if (Branch_Taken_EX) begin
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
         state_next  = IDLE;
         cnt_next    = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (hz) begin
                  stall = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_next = LSTALL;
                     cnt_next   = LAT_M1;
                  end
               end
            end
            LSTALL: begin
               stall = 1'b1;
               if (cnt_reg == DW'(1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - DW'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end

      if (stall) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (Stall_Clr)
         stall_cnt_next = '0;
      else if (stall && !(&stall_cnt_reg))
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign Stall     = stall;
   assign Stall_Cnt = stall_cnt_reg;

endmodule
